// File: rtl/fp_cmp_pkg.sv
// Shared types, constants and scalar comparators for the FP compare arbiter.
//   op_e    : request opcode (EQ, LT, LE, reserved)
//   state_e : arbiter FSM states
//   fp_feq / fp_flt / fp_is_nan : IEEE-754 single-precision helpers
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        OP_EQ  = 2'b00,
        OP_LT  = 2'b01,
        OP_LE  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam int         QNAN_BIT = 22;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] != 23'h0);
    endfunction

    // Quiet equality: NaN never compares equal, +0 equals -0.
    function automatic logic fp_feq(input logic [31:0] a, input logic [31:0] b);
        logic both_zero;
        both_zero = (a[30:0] == 31'h0) && (b[30:0] == 31'h0);
        return !fp_is_nan(a) && !fp_is_nan(b) && ((a == b) || both_zero);
    endfunction

    // Strict less-than on sign-magnitude encodings; zeros of either sign are equal.
    function automatic logic fp_flt(input logic [31:0] a, input logic [31:0] b);
        logic both_zero;
        logic lt;
        both_zero = (a[30:0] == 31'h0) && (b[30:0] == 31'h0);
        if (fp_is_nan(a) || fp_is_nan(b) || both_zero) begin
            lt = 1'b0;
        end else if (a[31] != b[31]) begin
            lt = a[31];
        end else if (!a[31]) begin
            lt = a[30:0] < b[30:0];
        end else begin
            lt = a[30:0] > b[30:0];
        end
        return lt;
    endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Purely combinational single-precision comparator.
//   a, b   : IEEE-754 single operands
//   op     : 00 EQ, 01 LT, 10 LE, 11 reserved
//   result : comparison outcome
//   nv     : invalid-operation flag
module fp_cmp_core
    import fp_cmp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic        result,
    output logic        nv
);

    logic nan_a, nan_b, snan_a, snan_b;
    logic eq, lt;

    always_comb begin
        nan_a  = fp_is_nan(a);
        nan_b  = fp_is_nan(b);
        snan_a = nan_a && !a[QNAN_BIT];
        snan_b = nan_b && !b[QNAN_BIT];
        eq     = fp_feq(a, b);
        lt     = fp_flt(a, b);

        result = 1'b0;
        nv     = 1'b0;
        unique case (op_e'(op))
            OP_EQ: begin
                result = eq;
                nv     = snan_a || snan_b;
            end
            OP_LT: begin
                result = lt;
                nv     = nan_a || nan_b;
            end
            OP_LE: begin
                result = lt || eq;
                nv     = nan_a || nan_b;
            end
            OP_RSV: begin
                result = 1'b0;
                nv     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fp_cmp_arb.sv
// Round-robin arbiter sharing one FP compare unit among NREQ requesters.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid / req_ready : per-requester request handshake (ready one-hot or zero)
//   req_a, req_b, req_op  : packed per-requester operands (32b each) and opcode (2b each)
//   rsp_valid / rsp_ready : per-requester response handshake (valid one-hot or zero)
//   rsp_result, rsp_nv    : registered result and invalid flag for the flagged requester
module fp_cmp_arb
    import fp_cmp_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ*2-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic                rsp_result,
    output logic                rsp_nv
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state, state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   cap_id;
    logic [31:0]     cap_a, cap_b;
    logic [1:0]      cap_op;
    logic            res_q, nv_q;
    logic            core_res, core_nv;
    logic            gnt_found;
    logic [PW-1:0]   gnt_id;
    int              idx;

    // Rotating priority search beginning at ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = PW'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        unique case (state)
            IDLE: begin
                if (gnt_found && !rst) begin
                    req_ready[gnt_id] = 1'b1;
                    state_next        = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid[cap_id] = 1'b1;
                // Only the owning requester's ready completes the response.
                if (rsp_ready[cap_id]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    fp_cmp_core u_core (
        .a      (cap_a),
        .b      (cap_b),
        .op     (cap_op),
        .result (core_res),
        .nv     (core_nv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cap_id <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_op <= '0;
            res_q  <= 1'b0;
            nv_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && gnt_found) begin
                cap_id <= gnt_id;
                cap_a  <= req_a[int'(gnt_id)*32 +: 32];
                cap_b  <= req_b[int'(gnt_id)*32 +: 32];
                cap_op <= req_op[int'(gnt_id)*2 +: 2];
                if (gnt_id == PW'(NREQ - 1)) ptr <= '0;
                else                         ptr <= gnt_id + 1'b1;
            end
            if (state == EXEC) begin
                res_q <= core_res;
                nv_q  <= core_nv;
            end
        end
    end

    assign rsp_result = res_q;
    assign rsp_nv     = nv_q;

endmodule

// File: tb/tb_fp_cmp_arb.sv
// Self-checking bench for fp_cmp_arb (NREQ=2): directed vectors, randomized
// operands against a real-arithmetic reference, arbitration, backpressure, reset.
module tb_fp_cmp_arb;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*32-1:0]  req_a, req_b;
    logic [NREQ*2-1:0]   req_op;
    logic                rsp_result, rsp_nv;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_cmp_arb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_nv     (rsp_nv)
    );

    // ---------------- reference model (numeric, via real) ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        real mag;
        int  e;
        e = int'(x[30:23]);
        if (e == 0)        mag = real'(x[22:0]) * pow2(-149);
        else if (e == 255) mag = 1.0e300;
        else               mag = (8388608.0 + real'(x[22:0])) * pow2(e - 150);
        return x[31] ? -mag : mag;
    endfunction

    function automatic bit m_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic bit m_snan(input logic [31:0] x);
        return m_nan(x) && (x[22] == 1'b0);
    endfunction

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         output logic res, output logic nv);
        bit anynan;
        anynan = m_nan(a) || m_nan(b);
        case (op)
            2'b00: begin res = !anynan && (f2r(a) == f2r(b)); nv = m_snan(a) || m_snan(b); end
            2'b01: begin res = !anynan && (f2r(a) <  f2r(b)); nv = anynan; end
            2'b10: begin res = !anynan && (f2r(a) <= f2r(b)); nv = anynan; end
            default: begin res = 1'b0; nv = 1'b1; end
        endcase
    endtask

    function automatic logic [31:0] gen_operand();
        logic [31:0] x;
        int unsigned k;
        k = $urandom_range(0, 7);
        x = $urandom;
        case (k)
            1: x = 32'h0000_0000;
            2: x = 32'h8000_0000;
            3: x = {x[31], 8'hFF, 23'h0};
            4: x = {x[31], 8'hFF, 1'b1, x[21:0]};
            5: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
            6: x = {x[31], 8'h7F, x[22:19], 19'h0};
            7: x = {x[31], 8'h00, x[22:0]};
            default: ;
        endcase
        return x;
    endfunction

    // Drives one request and returns what was observed; no checking here.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, output bit granted, output int lat,
                         output logic res, output logic nv, output logic [NREQ-1:0] vmask);
        granted = 0; lat = -1; res = 1'b0; nv = 1'b0; vmask = '0;
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_op[id*2 +: 2]  = op;
        rsp_ready = '0;
        for (int c = 0; c < 20 && !granted; c++) begin
            #1;
            if (req_ready[id]) granted = 1;
            else @(negedge clk);
        end
        if (!granted) begin
            req_valid = '0;
            return;
        end
        @(negedge clk);
        // Scramble inputs after the grant; the in-flight result must not change.
        req_valid = '0;
        req_a  = {$urandom, $urandom};
        req_b  = {$urandom, $urandom};
        req_op = (NREQ*2)'($urandom);
        for (int c = 1; c < 20; c++) begin
            if (rsp_valid != '0) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) begin
            vmask = rsp_valid;
            res   = rsp_result;
            nv    = rsp_nv;
            rsp_ready[id] = 1'b1;
            @(negedge clk);
            rsp_ready = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        n_cmp++;
        if (rsp_valid !== '0) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
        end
        n_cmp++;
        if ({rsp_result, rsp_nv} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp_fields: got %b expected 00", {rsp_result, rsp_nv});
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit g; int lat; logic r, n; logic [NREQ-1:0] vm;
        issue(0, 32'h3F80_0000, 32'h3F80_0000, 2'b00, g, lat, r, n, vm);
        n_cmp++;
        if (!g) begin n_fail++; $display("FAIL single_grant: got no grant expected grant"); end
        n_cmp++;
        if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_cmp++;
        if (vm !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 01", vm); end
        n_cmp++;
        if ({r, n} !== 2'b10) begin
            n_fail++; $display("FAIL single_result: got res=%b nv=%b expected res=1 nv=0", r, n);
        end
    endtask

    task automatic test_zero_sign();
        bit g; int lat; logic r, n; logic [NREQ-1:0] vm;
        issue(1, 32'h8000_0000, 32'h0000_0000, 2'b01, g, lat, r, n, vm);
        n_cmp++;
        if ({r, n} !== 2'b00) begin
            n_fail++; $display("FAIL zero_lt: got res=%b nv=%b expected res=0 nv=0", r, n);
        end
        issue(0, 32'h8000_0000, 32'h0000_0000, 2'b10, g, lat, r, n, vm);
        n_cmp++;
        if ({r, n} !== 2'b10) begin
            n_fail++; $display("FAIL zero_le: got res=%b nv=%b expected res=1 nv=0", r, n);
        end
    endtask

    task automatic test_nan();
        bit g; int lat; logic r, n; logic [NREQ-1:0] vm;
        issue(0, 32'h7FC0_0000, 32'h3F80_0000, 2'b00, g, lat, r, n, vm);
        n_cmp++;
        if ({r, n} !== 2'b00) begin
            n_fail++; $display("FAIL nan_eq_qnan: got res=%b nv=%b expected res=0 nv=0", r, n);
        end
        issue(1, 32'h7F80_0001, 32'h3F80_0000, 2'b00, g, lat, r, n, vm);
        n_cmp++;
        if ({r, n} !== 2'b01) begin
            n_fail++; $display("FAIL nan_eq_snan: got res=%b nv=%b expected res=0 nv=1", r, n);
        end
        issue(0, 32'h7FC0_0000, 32'h3F80_0000, 2'b01, g, lat, r, n, vm);
        n_cmp++;
        if ({r, n} !== 2'b01) begin
            n_fail++; $display("FAIL nan_lt_qnan: got res=%b nv=%b expected res=0 nv=1", r, n);
        end
        issue(1, 32'h3F80_0000, 32'h3F80_0000, 2'b11, g, lat, r, n, vm);
        n_cmp++;
        if ({r, n, lat == 2} !== 3'b011) begin
            n_fail++; $display("FAIL reserved_op: got res=%b nv=%b lat=%0d expected res=0 nv=1 lat=2",
                               r, n, lat);
        end
    endtask

    task automatic test_random();
        bit g; int lat; logic r, n, er, en; logic [NREQ-1:0] vm, evm;
        logic [31:0] a, b; logic [1:0] op; int id;
        for (int t = 0; t < 40; t++) begin
            a  = gen_operand();
            b  = ($urandom_range(0, 3) == 0) ? a : gen_operand();
            op = 2'($urandom_range(0, 3));
            id = int'($urandom_range(0, NREQ - 1));
            model(a, b, op, er, en);
            evm = '0;
            evm[id] = 1'b1;
            issue(id, a, b, op, g, lat, r, n, vm);
            n_cmp++;
            if (!g || lat != 2 || vm !== evm) begin
                n_fail++;
                $display("FAIL rand_handshake[%0d]: got grant=%0d lat=%0d vld=%b expected 1/2/%b",
                         t, g, lat, vm, evm);
            end
            n_cmp++;
            if ({r, n} !== {er, en}) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: a=%h b=%h op=%0d got res=%b nv=%b expected res=%b nv=%b",
                         t, a, b, op, r, n, er, en);
            end
        end
    endtask

    task automatic test_back_to_back();
        int grants[4];
        int ng, nr, gcyc;
        int cyc;
        do_reset();
        @(negedge clk);
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'h3F80_0000;
            req_b[i*32 +: 32] = 32'h4000_0000;
            req_op[i*2 +: 2]  = 2'b01;
        end
        rsp_ready = '1;
        ng = 0; nr = 0; gcyc = 0;
        for (cyc = 0; cyc < 40 && nr < 4; cyc++) begin
            #1;
            if (req_ready != '0 && ng < 4) begin
                grants[ng] = (req_ready == 2'b10) ? 1 : (req_ready == 2'b01) ? 0 : -1;
                gcyc = cyc;
                n_cmp++;
                if (grants[ng] != ng % NREQ) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: got ready=%b expected requester %0d",
                             ng, req_ready, ng % NREQ);
                end
                ng++;
            end
            if (rsp_valid != '0) begin
                n_cmp++;
                if (cyc - gcyc != 2 || rsp_result !== 1'b1 || rsp_valid != req_ready_of(grants[nr])) begin
                    n_fail++;
                    $display("FAIL rr_rsp[%0d]: got lat=%0d res=%b vld=%b expected lat=2 res=1 vld=%b",
                             nr, cyc - gcyc, rsp_result, rsp_valid, req_ready_of(grants[nr]));
                end
                nr++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (nr != 4) begin
            n_fail++; $display("FAIL rr_timeout: got %0d responses expected 4", nr);
        end
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
    endtask

    function automatic logic [NREQ-1:0] req_ready_of(input int id);
        logic [NREQ-1:0] m;
        m = '0;
        if (id >= 0 && id < NREQ) m[id] = 1'b1;
        return m;
    endfunction

    task automatic test_backpressure_reset();
        bit seen;
        logic er, en;
        model(32'h3F80_0000, 32'h3F80_0000, 2'b10, er, en);
        @(negedge clk);
        req_valid = 2'b10;
        req_a[32 +: 32] = 32'h3F80_0000;
        req_b[32 +: 32] = 32'h3F80_0000;
        req_op[2 +: 2]  = 2'b10;
        rsp_ready = '0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (req_ready[1]) seen = 1;
            @(negedge clk);
        end
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (rsp_valid != '0) seen = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL bp_timeout: got no response expected response"); end
        // The other requester's ready must not retire this response.
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 2'b10 || rsp_result !== er || rsp_nv !== en) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld=%b res=%b nv=%b expected vld=10 res=%b nv=%b",
                         c, rsp_valid, rsp_result, rsp_nv, er, en);
            end
        end
        rst = 1'b1;
        req_valid = '1;
        #1;
        n_cmp++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL rst_ready: got %b expected 00", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== '0 || rsp_result !== 1'b0 || rsp_nv !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort: got vld=%b res=%b nv=%b expected 00/0/0",
                               rsp_valid, rsp_result, rsp_nv);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rst_first_grant: got %b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) @(negedge clk);
        rsp_ready = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        test_reset();
        test_single();
        test_zero_sign();
        test_nan();
        test_random();
        test_back_to_back();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_cmp_arb.md
FP_CMP_ARB -- requirements
Module: fp_cmp_arb

Interface
REQ-001 SHALL have parameter: NREQ, 2, number of requesters sharing the compare unit (legal 2..4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req_valid  input  NREQ  per-requester request valid.
REQ-005 SHALL have port: req_ready  output  NREQ  per-requester request accept, one-hot or zero.
REQ-006 SHALL have port: req_a  input  NREQx32  operand A, IEEE-754 single.
REQ-007 SHALL have port: req_b  input  NREQx32  operand B, IEEE-754 single.
REQ-008 SHALL have port: req_op  input  NREQx2  00 EQ, 01 LT, 10 LE, 11 reserved.
REQ-009 SHALL have port: rsp_valid  output  NREQ  per-requester response valid, one-hot or zero.
REQ-010 SHALL have port: rsp_ready  input  NREQ  per-requester response accept.
REQ-011 SHALL have port: rsp_result  output  1  compare result for the requester flagged in rsp_valid.
REQ-012 SHALL have port: rsp_nv  output  1  invalid-operation flag for the same response.

Function
REQ-013 SHALL use FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: if any req_valid, grant one requester by round-robin, assert its req_ready combinationally that cycle, capture a/b/op/id, and go to EXEC. Otherwise stay in IDLE.
REQ-015 Round-robin: search starts at pointer ptr. After a grant to i, ptr becomes (i+1) mod NREQ. ptr is NREQ-bit-index wide and wraps from NREQ-1 to 0.
REQ-016 req_ready SHALL be zero in EXEC and RESP, so no new request is accepted while a transaction is in flight.
REQ-017 EXEC: evaluate the comparison on captured operands, register result and nv, and go to RESP. This is exactly one cycle.
REQ-018 RESP: hold rsp_valid[id], rsp_result and rsp_nv stable until rsp_ready[id]=1. In that cycle, return to IDLE. rsp_ready of other requesters is ignored.
REQ-019 Latency: acceptance at cycle T gives rsp_valid at T+2. Minimum issue interval is 3 cycles. A new grant may occur in the cycle after the response handshake.
REQ-020 EQ: result=1 iff neither operand is NaN and the operands are bitwise equal or both are zero (+0 == -0). nv=1 iff either operand is a signaling NaN.
REQ-021 LT: result=1 iff neither operand is NaN and A<B numerically. -0 is not less than +0. nv=1 iff either operand is any NaN.
REQ-022 LE: result = LT or EQ results. nv=1 iff either operand is any NaN.
REQ-023 NaN definition: exponent 0xFF with nonzero mantissa. A signaling NaN additionally has mantissa bit 22 = 0.
REQ-024 Reserved op 11: result=0 and nv=1, with normal handshake and latency.
REQ-025 Requester inputs SHALL only be sampled in the grant cycle. Later changes on req_* do not affect an in-flight transaction.
REQ-026 When requests arrive simultaneously, exactly one is granted per IDLE visit. Ungranted requesters keep req_valid asserted and are served in round-robin order, so no requester waits more than NREQ-1 other transactions.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_nv=0, captured registers=0.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the transaction with no response delivered. The first grant after reset favours requester 0.
REQ-029 While rst=1, req_ready SHALL be 0 regardless of req_valid.

Structure
REQ-030 Shared package fp_cmp_pkg SHALL hold: the op enum (OP_EQ, OP_LT, OP_LE, OP_RSV), the FSM state enum, and constants EXP_MAX=8'hFF and QNAN_BIT=22.
REQ-031 One sub-module, fp_cmp_core, SHALL be purely combinational. It takes a, b and op and produces result and nv, reusing the team's existing fp_feq and fp_flt comparators plus local NaN detection.
REQ-032 The arbiter, FSM and handshake logic SHALL reside in fp_cmp_arb. There SHALL be no combinational path from req_* to rsp_*.

Verification
REQ-033 Single request: requester 0, EQ, a=0x3F800000, b=0x3F800000. Expected: req_ready[0] in cycle T, rsp_valid[0] at T+2, result=1, nv=0.
REQ-034 Zero signs: LT with a=0x80000000, b=0x00000000 gives result=0, nv=0. LE with the same operands gives result=1, nv=0.
REQ-035 NaN: EQ with a=0x7FC00000, b=0x3F800000 gives result=0, nv=0. EQ with a=0x7F800001 gives nv=1. LT with a=0x7FC00000 gives result=0, nv=1.
REQ-036 Arbitration: both requesters hold valid continuously with LT a=0x3F800000, b=0x40000000. Grants SHALL alternate 0,1,0,1. Each response has result=1 and arrives 2 cycles after its grant.
REQ-037 Backpressure and reset: hold rsp_ready=0 for 5 cycles. rsp_valid and the response fields SHALL stay stable throughout. Asserting rst during RESP SHALL clear rsp_valid on the next edge, and the next grant SHALL go to requester 0.
